serial_frame_ctrl: RTL and testbench

- Sequencer for the team's serial-in shift register (bits enter at the MSB and shift toward the LSB).
- Gates shifting per frame and counts W bits.
- Hands the assembled word downstream through a one-entry valid/ready output slot.
- Flags overrun when a word completes while the slot is still occupied.
- Sits between a bit-level serial source (pin sampler, UART-style front end) and word-level consumers.

---
 rtl/serial_frame_ctrl_if.sv | 40 ++++
 rtl/serial_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_serial_frame_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_ctrl_if.sv
// Bus bundle for serial_frame_ctrl: bit-level input side, word output slot, status.
// The parity_err member exists only when SERIAL_FRAME_PARITY_EN is defined.
interface serial_frame_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic         bit_valid;
    logic         bit_in;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;
    logic         clear_overrun;
    logic [1:0]   state_dbg;
`ifdef SERIAL_FRAME_PARITY_EN
    logic         parity_err;

    modport master (
        output start, bit_valid, bit_in, out_ready, clear_overrun,
        input  out_data, out_valid, busy, overrun, state_dbg, parity_err
    );
    modport slave (
        input  start, bit_valid, bit_in, out_ready, clear_overrun,
        output out_data, out_valid, busy, overrun, state_dbg, parity_err
    );
`else
    modport master (
        output start, bit_valid, bit_in, out_ready, clear_overrun,
        input  out_data, out_valid, busy, overrun, state_dbg
    );
    modport slave (
        input  start, bit_valid, bit_in, out_ready, clear_overrun,
        output out_data, out_valid, busy, overrun, state_dbg
    );
`endif

    // Output slot handshake: a word transfers on any clock edge where out_valid and
    // out_ready are both high; out_data holds steady while out_valid=1 and out_ready=0.
endinterface

// File: rtl/serial_frame_ctrl.sv
// Frame sequencer for an MSB-entry serial shift register with a one-entry output slot.
// Optional SERIAL_FRAME_PARITY_EN adds a trailing even-parity bit and parity_err.
module serial_frame_ctrl #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    serial_frame_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(W + 1);
`ifdef SERIAL_FRAME_PARITY_EN
    localparam int SR_W = W;
`else
    // Without parity the word is built straight from the incoming bit, so the
    // register bit that would sit at position 0 never reaches a word.
    localparam int SR_W = W - 1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic [W-1:0]      shifted;
    logic [W-1:0]      word;
    logic              complete;
    logic              drop;
    logic              last_bit;
`ifdef SERIAL_FRAME_PARITY_EN
    logic              parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        complete    = 1'b0;
        drop        = 1'b0;
        shifted     = {bus.bit_in, sr_q[SR_W-1:SR_W-(W-1)]};
        last_bit    = (cnt_q == CNT_W'(W - 1));
`ifdef SERIAL_FRAME_PARITY_EN
        parity_err_d = parity_err_q;
        word         = sr_q;
`else
        word         = shifted;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    cnt_d = '0;
                    sr_d  = '0;
                end else if (bus.bit_valid) begin
                    sr_d = shifted[W-1:W-SR_W];
                    if (last_bit) begin
                        cnt_d = '0;
`ifdef SERIAL_FRAME_PARITY_EN
                        state_d = PARITY;
`else
                        state_d  = IDLE;
                        complete = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else if (bus.bit_valid) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // The slot can take a new word if it is empty or being drained this cycle.
        if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
                parity_err_d = (^sr_q) ^ bus.bit_in;
`endif
            end else begin
                drop = 1'b1;
            end
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef SERIAL_FRAME_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;
`ifdef SERIAL_FRAME_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl: frame-level model plus a word scoreboard.
// Honours SERIAL_FRAME_PARITY_EN when the design is built with it.
module tb_serial_frame_ctrl;
    localparam int W = 8;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic reset;

    serial_frame_ctrl_if #(.W(W)) sif();

    serial_frame_ctrl #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Frame model: collects bits by arrival index, delivers into a one-word slot.
    bit          m_busy  = 1'b0;
    int          m_nbits = 0;
    logic [FL-1:0] m_bits = '0;
    logic [W-1:0]  m_data = '0;
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          m_perr  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        bit done;
        bit old_valid;
        bit set_ovr;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_busy = 0; m_nbits = 0; m_bits = '0; m_data = '0;
                m_valid = 0; m_ovr = 0; m_perr = 0;
            end else begin
                done      = 0;
                set_ovr   = 0;
                old_valid = m_valid;
                if (m_busy) begin
                    if (sif.start) begin
                        m_nbits = 0;
                        m_bits  = '0;
                    end else if (sif.bit_valid) begin
                        m_bits[m_nbits] = sif.bit_in;
                        m_nbits++;
                        if (m_nbits == FL) begin
                            done    = 1;
                            m_busy  = 0;
                            m_nbits = 0;
                        end
                    end
                end else if (sif.start) begin
                    m_busy  = 1;
                    m_nbits = 0;
                    m_bits  = '0;
                end
                if (m_valid && sif.out_ready) m_valid = 0;
                if (done) begin
                    if (!old_valid || sif.out_ready) begin
                        m_data  = m_bits[W-1:0];
                        m_valid = 1;
                        m_perr  = ^m_bits;
                    end else begin
                        set_ovr = 1;
                    end
                end
                if (set_ovr) m_ovr = 1;
                else if (sif.clear_overrun) m_ovr = 0;
            end
        end
    end

    // Per-cycle compare against the model, and scoreboard pop on each transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("busy", sif.busy, m_busy);
            check("out_valid", sif.out_valid, m_valid);
            check("overrun", sif.overrun, m_ovr);
            check("out_data", sif.out_data, m_data);
`ifdef SERIAL_FRAME_PARITY_EN
            if (sif.out_valid) check("parity_err", sif.parity_err, m_perr);
`endif
            if (sif.out_valid && sif.out_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h required=none", sif.out_data);
                end else begin
                    check("sb_word", sif.out_data, exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [FL-1:0] frame_of(input logic [W-1:0] d, input bit bad_par);
`ifdef SERIAL_FRAME_PARITY_EN
        return {(^d) ^ bad_par, d};
`else
        return (bad_par) ? d : d;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_start();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
    endtask

    task automatic send_bits(input logic [FL-1:0] bits, input int nb, input int gap,
                             input bit last_ready, input bit last_clr);
        for (int i = 0; i < nb; i++) begin
            sif.bit_valid = 1'b1;
            sif.bit_in    = bits[i];
            if (i == nb - 1) begin
                sif.out_ready     = last_ready;
                sif.clear_overrun = last_clr;
            end
            tick();
            sif.bit_valid     = 1'b0;
            sif.clear_overrun = 1'b0;
            if (i != nb - 1) begin
                for (int g = 0; g < gap; g++) begin
                    sif.bit_in = ~sif.bit_in;
                    tick();
                end
            end
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input int gap,
                              input bit last_ready, input bit last_clr);
        send_start();
        send_bits(frame_of(d, 1'b0), FL, gap, last_ready, last_clr);
    endtask

    task automatic accept();
        sif.out_ready = 1'b1;
        tick();
        sif.out_ready = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        sif.start         = 1'b0;
        sif.bit_valid     = 1'b0;
        sif.bit_in        = 1'b0;
        sif.out_ready     = 1'b0;
        sif.clear_overrun = 1'b0;
        tick();
        tick();
        check("rst_busy", sif.busy, 0);
        check("rst_valid", sif.out_valid, 0);
        check("rst_overrun", sif.overrun, 0);
        check("rst_data", sif.out_data, 0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a frame, then a clean 0xA5 frame.
        send_start();
        send_bits('1, 4, 0, 1'b0, 1'b0);
        check("mid_busy", sif.busy, 1);
        reset = 1'b1;
        #1;
        check("async_busy", sif.busy, 0);
        check("async_valid", sif.out_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 0, 1'b0, 1'b0);
        check("a5_valid", sif.out_valid, 1);
        check("a5_data", sif.out_data, 8'hA5);
        accept();
        check("a5_drained", sif.out_valid, 0);

        // Back-to-back with the consumer always ready.
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        sif.out_ready = 1'b1;
        send_frame(8'h3C, 0, 1'b1, 1'b0);
        send_frame(8'hC3, 0, 1'b1, 1'b0);
        tick();
        sif.out_ready = 1'b0;
        check("b2b_overrun", sif.overrun, 0);
        check("b2b_valid", sif.out_valid, 0);

        // Old word drains on the same edge the new one loads.
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 0, 1'b0, 1'b0);
        send_frame(8'hC3, 0, 1'b1, 1'b0);
        check("same_edge_valid", sif.out_valid, 1);
        check("same_edge_data", sif.out_data, 8'hC3);
        check("same_edge_ovr", sif.overrun, 0);
        tick();
        sif.out_ready = 1'b0;
        check("same_edge_drained", sif.out_valid, 0);

        // Overrun: second word dropped, set beats clear, then clear alone.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 0, 1'b0, 1'b0);
        send_frame(8'h22, 0, 1'b0, 1'b0);
        check("ovr_data", sif.out_data, 8'h11);
        check("ovr_flag", sif.overrun, 1);
        send_frame(8'h33, 0, 1'b0, 1'b1);
        check("ovr_set_wins", sif.overrun, 1);
        check("ovr_data_kept", sif.out_data, 8'h11);
        sif.clear_overrun = 1'b1;
        tick();
        sif.clear_overrun = 1'b0;
        check("ovr_cleared", sif.overrun, 0);
        accept();

        // Restart discards the partial frame.
        exp_q.push_back(8'h0F);
        send_start();
        send_bits('1, 5, 0, 1'b0, 1'b0);
        send_frame(8'h0F, 0, 1'b0, 1'b0);
        check("restart_data", sif.out_data, 8'h0F);
        accept();

        // Gapped strobes with bit_in toggling between them; data held under backpressure.
        exp_q.push_back(8'h81);
        send_frame(8'h81, 2, 1'b0, 1'b0);
        check("gap_data", sif.out_data, 8'h81);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("gap_hold", sif.out_data, 8'h81);
        end
        accept();

`ifdef SERIAL_FRAME_PARITY_EN
        exp_q.push_back(8'h07);
        send_frame(8'h07, 0, 1'b0, 1'b0);
        check("par_good_valid", sif.out_valid, 1);
        check("par_good_err", sif.parity_err, 0);
        accept();
        exp_q.push_back(8'h07);
        send_start();
        send_bits(frame_of(8'h07, 1'b1), FL, 0, 1'b0, 1'b0);
        check("par_bad_err", sif.parity_err, 1);
        accept();
`endif

        tick();
        tick();
        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
